// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning the HI/LO registers.
// Results are computed at start and held internally until the cycle counter expires.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5
    } md_op_e;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     rhi_q, rhi_d, rlo_q, rlo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        b_zero;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign b_zero = (B == 32'd0);
    assign a_mag  = A[31] ? (32'd0 - A) : A;
    assign b_mag  = B[31] ? (32'd0 - B) : B;
    assign q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
    assign r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
    assign quot_s = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    assign rem_s  = A[31] ? (32'd0 - r_mag) : r_mag;
    assign quot_u = b_zero ? 32'd0 : (A / B);
    assign rem_u  = b_zero ? 32'd0 : (A % B);

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        rhi_d = rhi_q;
        rlo_d = rlo_q;
        if (cnt_q != '0) begin
            if (Cancel) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    hi_d = rhi_q;
                    lo_d = rlo_q;
                end
            end
        end else if (Start && !Cancel) begin
            case (MDOp)
                OpMult: begin
                    {rhi_d, rlo_d} = prod_s;
                    cnt_d          = CntW'(MULT_CYCLES);
                end
                OpMultu: begin
                    {rhi_d, rlo_d} = prod_u;
                    cnt_d          = CntW'(MULT_CYCLES);
                end
                OpDiv: begin
                    rhi_d = b_zero ? A : rem_s;
                    rlo_d = b_zero ? 32'hFFFF_FFFF : quot_s;
                    cnt_d = CntW'(DIV_CYCLES);
                end
                OpDivu: begin
                    rhi_d = b_zero ? A : rem_u;
                    rlo_d = b_zero ? 32'hFFFF_FFFF : quot_u;
                    cnt_d = CntW'(DIV_CYCLES);
                end
                OpMthi:  hi_d = A;
                OpMtlo:  lo_d = A;
                default: ;
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            rhi_q  <= 32'd0;
            rlo_q  <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            rhi_q  <= rhi_d;
            rlo_q  <= rlo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
